i2c_tx_fifo: RTL and testbench
==============================

# i2c_tx_fifo

Transmit-data FIFO sitting directly upstream of the I2C master state machine. The AXI register write path pushes payload bytes; the I2C FSM pops one byte per transmitted data byte through its read-request / data-from-FIFO pair. Provides first-word-fall-through output, occupancy count and sticky overflow/underflow flags for the status register.

## Interface
Parameters:
- DATA_WIDTH, 8, stored bits per entry (low bits of wr_data)
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), pointer index width (derived, not overridden)

Ports:
- axi_clk  in  1  system clock (100 MHz); all state changes on rising edge
- axi_reset  in  1  reset, **asynchronous, active-high**
- wr_request  in  1  push strobe, one entry per cycle high
- wr_data  in  32  push data; bits [DATA_WIDTH-1:0] stored, rest ignored
- rd_request  in  1  pop strobe from I2C FSM, one entry per cycle high
- rd_data  out  32  head entry, zero-extended; 0 when empty
- clear  in  1  synchronous flush of all entries
- clear_flags  in  1  clears overflow and underflow
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push attempted while full and not popping
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×DATA_WIDTH register array; wr_ptr, rd_ptr are ADDR_WIDTH+1 bits, index with low ADDR_WIDTH bits, MSB disambiguates full/empty. Pointers wrap naturally modulo 2·DEPTH.
- Push accepted = wr_request & (!full | pop accepted); writes mem[wr_ptr], wr_ptr+1.
- Pop accepted = rd_request & !empty; rd_ptr+1. No bypass: pop on empty is rejected even if a push occurs the same cycle.
- count: +1 push only, −1 pop only, unchanged on both or neither.
- Rejected push (wr_request & full & !pop) → data dropped, overflow ← 1.
- Rejected pop (rd_request & empty) → pointers unchanged, underflow ← 1.
- clear: highest priority; pointers and count ← 0; same-cycle push/pop ignored and raise no flag. Flags are not affected by clear.
- clear_flags: overflow, underflow ← 0, unless a new flag event occurs the same cycle (set wins).
- rd_data = {zeros, mem[rd_ptr[ADDR_WIDTH-1:0]]} when !empty, else 32'h0.
- Memory contents not reset; output gating on empty makes them unobservable.

## Timing
- Reset (asserted asynchronously, any time, incl. mid-burst): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, rd_data = 0. Outputs valid immediately on assertion; first push accepted on first rising edge after deassertion.
- Push at edge N → count, empty, full, rd_data updated in cycle after edge N (1-cycle latency, write to read-visible).
- Pop at edge N → next entry on rd_data in cycle after edge N; FSM samples rd_data before asserting rd_request (first-word-fall-through).
- full, empty, count are registered/derived from registered pointers; no combinational path from wr_request/rd_request to any output.
- Sustained 1 push + 1 pop per cycle at any occupancy 1..DEPTH: count constant, no flags.
- Flags update on the edge of the offending request; visible the next cycle.

## Test plan
- Reset, then push 8'hA5: next cycle empty=0, count=1, rd_data=32'h0000_00A5; pop → empty=1, rd_data=0, no flags.
- Push DEPTH entries 0x00..0x0F: full=1, count=16; extra push 0xFF → overflow=1, count stays 16; pop all → order 0x00..0x0F, empty=1.
- Fill to full, assert wr_request and rd_request together with 0x55: count stays 16, overflow=0, head advances, 0x55 emerges last.
- Pop on empty with simultaneous push 0x3C: underflow=1, count=1, rd_data=0x3C; clear_flags with no event → both flags 0.
- Push 3 entries, assert clear with simultaneous push: count=0, empty=1, no overflow; then 40 push/pop pairs cross pointer wrap with correct data order.
- Assert axi_reset asynchronously (between clock edges) with count=5: outputs go to reset values before next edge; after deassertion FIFO behaves as empty.

Source files
------------

// File: rtl/i2c_tx_fifo.sv
// rtl/i2c_tx_fifo.sv - transmit-data FIFO feeding the I2C master FSM
module i2c_tx_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  wr_request,
    input  logic [31:0]           wr_data,
    input  logic                  rd_request,
    output logic [31:0]           rd_data,
    input  logic                  clear,
    input  logic                  clear_flags,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pop_ok, push_ok, wr_en;

    // Status derived only from registered pointers; the extra MSB tells full from empty
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    end

    // Head entry falls through to the FSM, forced to zero when nothing is stored
    always_comb begin
        rd_data = 32'h0;
        if (!empty) begin
            rd_data[DATA_WIDTH-1:0] = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Accept/reject decisions, pointer advance and sticky flag updates
    always_comb begin
        pop_ok      = rd_request && !empty;
        push_ok     = wr_request && (!full || pop_ok);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en       = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (clear) begin
            // Flush wins over any same-cycle traffic, which also raises no flag
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            // A new event beats a same-cycle clear_flags
            if (wr_request && full && !pop_ok) begin
                overflow_d = 1'b1;
            end
            if (rd_request && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Pointer and flag registers
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; left unreset because empty gating hides stale contents
    always_ff @(posedge axi_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data[DATA_WIDTH-1:0];
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb/tb_i2c_tx_fifo.sv - self-checking bench for i2c_tx_fifo
module tb_i2c_tx_fifo;

    localparam int DEPTH = 16;

    logic        axi_clk;
    logic        axi_reset;
    logic        wr_request;
    logic [31:0] wr_data;
    logic        rd_request;
    logic [31:0] rd_data;
    logic        clear;
    logic        clear_flags;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] last_pop;

    i2c_tx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
        .axi_clk    (axi_clk),
        .axi_reset  (axi_reset),
        .wr_request (wr_request),
        .wr_data    (wr_data),
        .rd_request (rd_request),
        .rd_data    (rd_data),
        .clear      (clear),
        .clear_flags(clear_flags),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    // One clock of stimulus: scoreboard pop-compare before the edge, model update, state compare after
    task automatic cycle(input logic wr, input logic [31:0] wd, input logic rd,
                         input logic clr, input logic clrf);
        int   sz;
        logic pop, push, full_m;
        sz     = q.size();
        pop    = rd && (sz > 0);
        full_m = (sz == DEPTH);
        push   = wr && (!full_m || pop);

        n_checks++;
        if (sz == 0) begin
            if (rd_data !== 32'h0) $display("FAIL empty_rd_data got=%h exp=0", rd_data);
            else n_pass++;
        end else begin
            if (rd_data !== {24'h0, q[0]}) $display("FAIL head_data got=%h exp=%h", rd_data, q[0]);
            else n_pass++;
        end

        if (clrf) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (clr) begin
            q.delete();
        end else begin
            if (wr && full_m && !pop) m_ovf = 1'b1;
            if (rd && sz == 0) m_unf = 1'b1;
            if (pop) last_pop = q.pop_front();
            if (push) q.push_back(wd[7:0]);
        end

        wr_request  = wr;
        wr_data     = wd;
        rd_request  = rd;
        clear       = clr;
        clear_flags = clrf;
        @(posedge axi_clk);
        #1;
        wr_request  = 1'b0;
        wr_data     = 32'h0;
        rd_request  = 1'b0;
        clear       = 1'b0;
        clear_flags = 1'b0;

        n_checks++;
        if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH))
            $display("FAIL state count=%0d empty=%b full=%b exp_count=%0d", count, empty, full, q.size());
        else n_pass++;
        n_checks++;
        if (overflow !== m_ovf || underflow !== m_unf)
            $display("FAIL flags ovf=%b unf=%b exp_ovf=%b exp_unf=%b", overflow, underflow, m_ovf, m_unf);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            underflow !== 1'b0 || rd_data !== 32'h0)
            $display("FAIL reset_state count=%0d empty=%b full=%b ovf=%b unf=%b rd=%h exp=0/1/0/0/0/0",
                     count, empty, full, overflow, underflow, rd_data);
        else n_pass++;
    endtask

    task automatic test_single();
        cycle(1'b1, 32'hDEAD_BEA5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b0 || count !== 5'd1 || rd_data !== 32'h0000_00A5)
            $display("FAIL single_push empty=%b count=%0d rd=%h exp=0/1/000000a5", empty, count, rd_data);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || rd_data !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL single_pop empty=%b rd=%h ovf=%b unf=%b exp=1/0/0/0", empty, rd_data, overflow, underflow);
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || count !== 5'd16)
            $display("FAIL fill full=%b count=%0d exp=1/16", full, count);
        else n_pass++;
        cycle(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 5'd16)
            $display("FAIL overflow ovf=%b count=%0d exp=1/16", overflow, count);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || last_pop !== 8'h0F)
            $display("FAIL drain empty=%b last=%h exp=1/0f", empty, last_pop);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_data !== 32'h81)
            $display("FAIL full_simul count=%0d ovf=%b head=%h exp=16/0/81", count, overflow, rd_data);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (last_pop !== 8'h55 || empty !== 1'b1)
            $display("FAIL full_simul_last last=%h empty=%b exp=55/1", last_pop, empty);
        else n_pass++;
    endtask

    task automatic test_underflow_bypass();
        cycle(1'b1, 32'h3C, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (underflow !== 1'b1 || count !== 5'd1 || rd_data !== 32'h3C)
            $display("FAIL underflow unf=%b count=%0d rd=%h exp=1/1/3c", underflow, count, rd_data);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL clear_flags ovf=%b unf=%b exp=0/0", overflow, underflow);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        // pop on empty together with clear_flags: the new event must win
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (underflow !== 1'b1)
            $display("FAIL set_wins unf=%b exp=1", underflow);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_wrap();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_data !== 32'h0)
            $display("FAIL clear count=%0d empty=%b ovf=%b rd=%h exp=0/1/0/0", count, empty, overflow, rd_data);
        else n_pass++;
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) cycle(1'b1, 32'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd1)
            $display("FAIL wrap_count count=%0d exp=1", count);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd5)
            $display("FAIL pre_reset count=%0d exp=5", count);
        else n_pass++;
        #2;
        axi_reset = 1'b1;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 32'h0 ||
            overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL async_reset count=%0d empty=%b full=%b rd=%h ovf=%b unf=%b exp=0/1/0/0/0/0",
                     count, empty, full, rd_data, overflow, underflow);
        else n_pass++;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge axi_clk);
        #5;
        axi_reset = 1'b0;
        @(posedge axi_clk);
        #1;
        cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (last_pop !== 8'h77 || empty !== 1'b1)
            $display("FAIL post_reset last=%h empty=%b exp=77/1", last_pop, empty);
        else n_pass++;
    endtask

    initial begin
        axi_reset   = 1'b1;
        wr_request  = 1'b0;
        wr_data     = 32'h0;
        rd_request  = 1'b0;
        clear       = 1'b0;
        clear_flags = 1'b0;
        last_pop    = 8'h0;
        @(posedge axi_clk);
        #1;
        test_reset();
        #4;
        axi_reset = 1'b0;
        @(posedge axi_clk);
        #1;
        test_single();
        test_fill_overflow();
        test_full_simul();
        test_underflow_bypass();
        test_clear_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
